// File: rtl/alu_pkg.sv
// alu_pkg: constants shared by the shared-ALU arbiter slice.
//   - ALU opcode encodings (2-bit alu_control)
//   - requester identifiers carried in rsp_id
package alu_pkg;

   localparam int unsigned ALU_W = 32;

   localparam logic [1:0] ALU_ADD   = 2'd0;
   localparam logic [1:0] ALU_AND   = 2'd1;
   localparam logic [1:0] ALU_PASSB = 2'd2;
   localparam logic [1:0] ALU_ZERO  = 2'd3;

   localparam logic REQ0 = 1'b0;
   localparam logic REQ1 = 1'b1;

endpackage : alu_pkg

// File: rtl/alu.sv
// alu: purely combinational shared ALU.
// Ports:
//   a, b         in  WIDTH  operands
//   alu_control  in  2      0=ADD (mod 2^WIDTH), 1=AND, 2=PASS B, 3=zero
//   result       out WIDTH  operation result
module alu
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [1:0]       alu_control,
   output logic [WIDTH-1:0] result
);

   // Operation select; carry out of the adder is intentionally dropped.
   always_comb begin
      result = {WIDTH{1'b0}};
      case (alu_control)
         ALU_ADD:   result = a + b;
         ALU_AND:   result = a & b;
         ALU_PASSB: result = b;
         ALU_ZERO:  result = {WIDTH{1'b0}};
         default:   result = {WIDTH{1'b0}};
      endcase
   end

endmodule : alu

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between two valid/ready
// requesters with a round-robin grant and a one-entry response register.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   reqN_valid/ready           request handshake for requester N (0/1)
//   reqN_a, reqN_b, reqN_op    operands and opcode of requester N
//   rsp_valid/ready            response handshake
//   rsp_id, rsp_result         requester ID and ALU result held in the register
//   gnt_cnt0, gnt_cnt1         saturating per-requester grant counters
module alu_arbiter
   import alu_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,

   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic [1:0]       req0_op,

   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   input  logic [1:0]       req1_op,

   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic             rsp_id,
   output logic [WIDTH-1:0] rsp_result,

   output logic [CNT_W-1:0] gnt_cnt0,
   output logic [CNT_W-1:0] gnt_cnt1
);

   logic             rsp_valid_q, rsp_valid_d;
   logic             rsp_id_q,    rsp_id_d;
   logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
   logic             ptr_q,       ptr_d;
   logic [CNT_W-1:0] cnt0_q,      cnt0_d;
   logic [CNT_W-1:0] cnt1_q,      cnt1_d;

   logic             can_accept;
   logic             gnt0, gnt1;
   logic             xfer;
   logic [WIDTH-1:0] alu_a, alu_b, alu_result;
   logic [1:0]       alu_op;

   // Round-robin grant. Nothing is granted during reset or while a held
   // response is being back-pressured.
   always_comb begin
      can_accept = !rsp_valid_q || rsp_ready;
      gnt0       = 1'b0;
      gnt1       = 1'b0;
      if (reset || !can_accept) begin
         gnt0 = 1'b0;
         gnt1 = 1'b0;
      end else if (req0_valid && req1_valid) begin
         if (ptr_q == REQ0) begin
            gnt0 = 1'b1;
         end else begin
            gnt1 = 1'b1;
         end
      end else if (req0_valid) begin
         gnt0 = 1'b1;
      end else if (req1_valid) begin
         gnt1 = 1'b1;
      end else begin
         gnt0 = 1'b0;
         gnt1 = 1'b0;
      end
      xfer = gnt0 || gnt1;
   end

   assign req0_ready = gnt0;
   assign req1_ready = gnt1;

   // Grant mux into the ALU; idle inputs are forced to zero.
   always_comb begin
      alu_a  = {WIDTH{1'b0}};
      alu_b  = {WIDTH{1'b0}};
      alu_op = 2'd0;
      if (gnt0) begin
         alu_a  = req0_a;
         alu_b  = req0_b;
         alu_op = req0_op;
      end else if (gnt1) begin
         alu_a  = req1_a;
         alu_b  = req1_b;
         alu_op = req1_op;
      end else begin
         alu_a  = {WIDTH{1'b0}};
         alu_b  = {WIDTH{1'b0}};
         alu_op = 2'd0;
      end
   end

   alu #(
      .WIDTH (WIDTH)
   ) u_alu (
      .a           (alu_a),
      .b           (alu_b),
      .alu_control (alu_op),
      .result      (alu_result)
   );

   // Response register, priority pointer and grant counters next state.
   // A new transfer overwrites the register in the same edge that the
   // consumer drains it, giving one op per cycle.
   always_comb begin
      rsp_valid_d  = rsp_valid_q;
      rsp_id_d     = rsp_id_q;
      rsp_result_d = rsp_result_q;
      ptr_d        = ptr_q;
      cnt0_d       = cnt0_q;
      cnt1_d       = cnt1_q;

      if (xfer) begin
         rsp_valid_d  = 1'b1;
         rsp_id_d     = gnt1 ? REQ1 : REQ0;
         rsp_result_d = alu_result;
         // The requester not granted gets priority next, contended or not.
         ptr_d        = gnt1 ? REQ0 : REQ1;
      end else if (rsp_valid_q && rsp_ready) begin
         rsp_valid_d  = 1'b0;
      end else begin
         rsp_valid_d  = rsp_valid_q;
      end

      if (gnt0 && !(&cnt0_q)) begin
         cnt0_d = cnt0_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
         cnt0_d = cnt0_q;
      end

      if (gnt1 && !(&cnt1_q)) begin
         cnt1_d = cnt1_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
         cnt1_d = cnt1_q;
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         rsp_valid_q  <= 1'b0;
         rsp_id_q     <= REQ0;
         rsp_result_q <= {WIDTH{1'b0}};
         ptr_q        <= REQ0;
         cnt0_q       <= {CNT_W{1'b0}};
         cnt1_q       <= {CNT_W{1'b0}};
      end else begin
         rsp_valid_q  <= rsp_valid_d;
         rsp_id_q     <= rsp_id_d;
         rsp_result_q <= rsp_result_d;
         ptr_q        <= ptr_d;
         cnt0_q       <= cnt0_d;
         cnt1_q       <= cnt1_d;
      end
   end

   assign rsp_valid  = rsp_valid_q;
   assign rsp_id     = rsp_id_q;
   assign rsp_result = rsp_result_q;
   assign gnt_cnt0   = cnt0_q;
   assign gnt_cnt1   = cnt1_q;

endmodule : alu_arbiter
